// File: rtl/arcade_joy_mapper_pkg.sv
// Shared types for the arcade player-input conditioner: joystick bit indices,
// the packed direction nibble and the coin FSM states.
package arcade_input_pkg;

    localparam int unsigned JOY_WORD_W = 16;
    localparam int unsigned JOY_USED_W = 6;

    // Bit positions inside one 16-bit MiSTer joystick word.
    typedef enum logic [2:0] {
        RIGHT = 3'd0,
        LEFT  = 3'd1,
        DOWN  = 3'd2,
        UP    = 3'd3,
        COIN  = 3'd4,
        START = 3'd5
    } joy_bit_e;

    // Direction nibble in the order the core's input ports expect.
    typedef struct packed {
        logic left;
        logic down;
        logic right;
        logic up;
    } dir4_t;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } coin_state_e;

    // Highest-priority held direction as one-hot: up > down > left > right.
    function automatic logic [3:0] dir4_prio(input logic [3:0] d);
        logic [3:0] r;
        r = 4'b0000;
        if (d[0]) begin
            r = 4'b0001;
        end else if (d[2]) begin
            r = 4'b0100;
        end else if (d[3]) begin
            r = 4'b1000;
        end else if (d[1]) begin
            r = 4'b0010;
        end
        return r;
    endfunction

endpackage

// File: rtl/arcade_joy_mapper_if.sv
// Bundle between the joystick source / core inputs and arcade_joy_mapper.
// master drives frame strobe and joystick words; slave is the mapper.
interface arcade_joy_mapper_if #(
    parameter int unsigned PLAYERS = 2
);
    logic                   ce_frame;
    logic [PLAYERS*16-1:0]  joy;
    logic [PLAYERS*4-1:0]   dir_n;
    logic [PLAYERS-1:0]     start_n;
    logic                   coin_n;
    logic [7:0]             coin_count;

    modport master (
        output ce_frame,
        output joy,
        input  dir_n,
        input  start_n,
        input  coin_n,
        input  coin_count
    );

    modport slave (
        input  ce_frame,
        input  joy,
        output dir_n,
        output start_n,
        output coin_n,
        output coin_count
    );
endinterface

// File: rtl/arcade_joy_mapper_fourway.sv
// joy_fourway: reduces four debounced directions to at most one active
// direction. The most recently pressed direction wins; on its release the
// highest-priority direction still held takes over.
module joy_fourway
    import arcade_input_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] dir_in,
    output logic [3:0] dir_out_n
);

    logic [3:0] prev_q;
    logic [3:0] last_q;
    logic [3:0] last_d;
    logic [3:0] rise;

    // Choose the new winning direction from fresh presses or a released winner.
    always_comb begin
        last_d = last_q;
        rise   = dir_in & ~prev_q;
        if (|rise) begin
            last_d = dir4_prio(rise);
        end else if (|(last_q & ~dir_in)) begin
            last_d = dir4_prio(dir_in);
        end
    end

    // State: previous inputs for edge detection and the current winner.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 4'b0000;
            last_q <= 4'b0000;
        end else begin
            prev_q <= dir_in;
            last_q <= last_d;
        end
    end

    assign dir_out_n = ~last_q;

endmodule

// File: rtl/arcade_joy_mapper.sv
// arcade_joy_mapper: per-player debounce, optional 4-way direction
// resolution, start buttons and a shaped coin pulse with one queued insert.
// Optional feature: define JOY_FOURWAY_EN to restrict each player to one
// active direction; otherwise debounced directions pass through inverted.
module arcade_joy_mapper
    import arcade_input_pkg::*;
#(
    parameter int unsigned PLAYERS         = 2,
    parameter int unsigned DEBOUNCE_FRAMES = 2,
    parameter int unsigned COIN_FRAMES     = 4,
    parameter int unsigned COIN_GAP_FRAMES = 4
) (
    input logic                clk,
    input logic                reset_n,
    arcade_joy_mapper_if.slave bus
);

    localparam int unsigned NBITS = PLAYERS * JOY_USED_W;
    localparam int unsigned CNT_W =
        (DEBOUNCE_FRAMES > 0) ? $clog2(DEBOUNCE_FRAMES + 1) : 1;

    logic [NBITS-1:0]     raw_d;
    logic [NBITS-1:0]     raw_q;
    logic [NBITS-1:0]     deb;
    dir4_t [PLAYERS-1:0]  dirs;
    logic [PLAYERS-1:0]   start_deb;
    logic [PLAYERS-1:0]   start_n_q;
    logic [PLAYERS*4-1:0] dir_n_w;
    logic                 coin_any;

    // Upper joystick bits carry no function here.
    logic unused_joy;
    assign unused_joy = ^bus.joy;

    // Gather the six used bits of every player into one flat vector.
    always_comb begin
        raw_d = '0;
        for (int unsigned p = 0; p < PLAYERS; p++) begin
            for (int unsigned b = 0; b < JOY_USED_W; b++) begin
                raw_d[p*JOY_USED_W + b] = bus.joy[p*JOY_WORD_W + b];
            end
        end
    end

    // Input register; joy is already in the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw_q <= '0;
        end else begin
            raw_q <= raw_d;
        end
    end

    generate
        if (DEBOUNCE_FRAMES == 0) begin : g_no_deb
            assign deb = raw_q;
        end else begin : g_deb
            logic [NBITS-1:0][CNT_W-1:0] cnt_q;
            logic [NBITS-1:0][CNT_W-1:0] cnt_d;
            logic [NBITS-1:0]            deb_q;
            logic [NBITS-1:0]            deb_d;

            // Count frames a bit disagrees with its debounced value; accept on the last one.
            always_comb begin
                cnt_d = cnt_q;
                deb_d = deb_q;
                if (bus.ce_frame) begin
                    for (int unsigned i = 0; i < NBITS; i++) begin
                        if (raw_q[i] != deb_q[i]) begin
                            if (cnt_q[i] == CNT_W'(DEBOUNCE_FRAMES - 1)) begin
                                deb_d[i] = raw_q[i];
                                cnt_d[i] = '0;
                            end else begin
                                cnt_d[i] = cnt_q[i] + CNT_W'(1);
                            end
                        end else begin
                            cnt_d[i] = '0;
                        end
                    end
                end
            end

            // Debounce counters and accepted values.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                    deb_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                    deb_q <= deb_d;
                end
            end

            assign deb = deb_q;
        end
    endgenerate

    // Split debounced bits into direction nibbles, start bits and the shared coin.
    always_comb begin
        dirs      = '0;
        start_deb = '0;
        coin_any  = 1'b0;
        for (int unsigned p = 0; p < PLAYERS; p++) begin
            dirs[p].left  = deb[p*JOY_USED_W + 32'(LEFT)];
            dirs[p].down  = deb[p*JOY_USED_W + 32'(DOWN)];
            dirs[p].right = deb[p*JOY_USED_W + 32'(RIGHT)];
            dirs[p].up    = deb[p*JOY_USED_W + 32'(UP)];
            start_deb[p]  = deb[p*JOY_USED_W + 32'(START)];
            coin_any      = coin_any | deb[p*JOY_USED_W + 32'(COIN)];
        end
    end

`ifdef JOY_FOURWAY_EN
    generate
        for (genvar p = 0; p < int'(PLAYERS); p++) begin : g_fourway
            joy_fourway u_fourway (
                .clk       (clk),
                .reset_n   (reset_n),
                .dir_in    (dirs[p]),
                .dir_out_n (dir_n_w[p*4 +: 4])
            );
        end
    endgenerate
`else
    // Pass-through: debounced directions inverted, combinations left intact.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir_n_w <= '1;
        end else begin
            dir_n_w <= ~dirs;
        end
    end
`endif

    // Start buttons: debounced value inverted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_n_q <= '1;
        end else begin
            start_n_q <= ~start_deb;
        end
    end

    // Coin pulse shaper.
    coin_state_e state_q;
    coin_state_e state_d;
    logic [7:0]  timer_q;
    logic [7:0]  timer_d;
    logic        pending_q;
    logic        pending_d;
    logic        coin_prev_q;
    logic        coin_edge;
    logic        coin_n_q;
    logic [7:0]  coin_count_q;
    logic [7:0]  coin_count_d;

    // Next-state logic for the coin pulse, queued insert and counter.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        pending_d    = pending_q;
        coin_count_d = coin_count_q;
        coin_edge    = coin_any & ~coin_prev_q;
        case (state_q)
            IDLE: begin
                if (coin_edge) begin
                    state_d      = PULSE;
                    timer_d      = 8'(COIN_FRAMES);
                    coin_count_d = coin_count_q + 8'd1;
                end
            end
            PULSE: begin
                if (coin_edge) begin
                    pending_d = 1'b1;
                end
                if (bus.ce_frame) begin
                    if (timer_q <= 8'd1) begin
                        state_d = GAP;
                        timer_d = 8'(COIN_GAP_FRAMES);
                    end else begin
                        timer_d = timer_q - 8'd1;
                    end
                end
            end
            GAP: begin
                if (bus.ce_frame && timer_q <= 8'd1) begin
                    // An edge landing on the final gap strobe counts as queued.
                    if (pending_q || coin_edge) begin
                        state_d      = PULSE;
                        timer_d      = 8'(COIN_FRAMES);
                        pending_d    = 1'b0;
                        coin_count_d = coin_count_q + 8'd1;
                    end else begin
                        state_d = IDLE;
                        timer_d = 8'd0;
                    end
                end else begin
                    if (coin_edge) begin
                        pending_d = 1'b1;
                    end
                    if (bus.ce_frame) begin
                        timer_d = timer_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Coin FSM registers; coin_n is registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            timer_q      <= 8'd0;
            pending_q    <= 1'b0;
            coin_prev_q  <= 1'b0;
            coin_n_q     <= 1'b1;
            coin_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
            coin_prev_q  <= coin_any;
            coin_n_q     <= (state_d != PULSE);
            coin_count_q <= coin_count_d;
        end
    end

    assign bus.dir_n      = dir_n_w;
    assign bus.start_n    = start_n_q;
    assign bus.coin_n     = coin_n_q;
    assign bus.coin_count = coin_count_q;

endmodule

// File: tb/tb_arcade_joy_mapper.sv
// Bench for arcade_joy_mapper: directed and random joystick activity, a
// frame-level reference model, and a scoreboard drained on the falling edge.
module tb_arcade_joy_mapper;

    localparam int P  = 3;
    localparam int DB = 2;
    localparam int CF = 4;
    localparam int CG = 4;
    localparam int M_IDLE  = 0;
    localparam int M_PULSE = 1;
    localparam int M_GAP   = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    arcade_joy_mapper_if #(.PLAYERS(P)) bus ();

    arcade_joy_mapper #(
        .PLAYERS         (P),
        .DEBOUNCE_FRAMES (DB),
        .COIN_FRAMES     (CF),
        .COIN_GAP_FRAMES (CG)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, all held as plain per-player arrays.
    logic [P*16-1:0] m_raw;
    logic [5:0]      m_deb [P];
    int              m_cnt [P][6];
    logic [3:0]      m_prev [P];
    int              m_last [P];
    int              mc_mode, mc_left, mc_pend, mc_count;
    logic            mc_prev;
    logic [P*4+P+1+8-1:0] exp_q [$];
    logic [P*16-1:0] joy_v;

    function automatic int nib_pos(input int b);
        case (b)
            3: return 0;
            0: return 1;
            2: return 2;
            default: return 3;
        endcase
    endfunction

    // First held direction in priority order up, down, left, right; -1 if none.
    function automatic int first_held(input logic [3:0] d);
        int order [4];
        order = '{3, 2, 1, 0};
        for (int k = 0; k < 4; k++) if (d[order[k]]) return order[k];
        return -1;
    endfunction

    task automatic model_reset();
        m_raw = '0;
        for (int p = 0; p < P; p++) begin
            m_deb[p] = '0;
            m_prev[p] = '0;
            m_last[p] = -1;
            for (int b = 0; b < 6; b++) m_cnt[p][b] = 0;
        end
        mc_mode = M_IDLE; mc_left = 0; mc_pend = 0; mc_count = 0; mc_prev = 1'b0;
    endtask

    // One clock of the model: outputs follow the debounced state held before the edge.
    task automatic model_step(input logic [P*16-1:0] j, input logic ce);
        logic [P*4-1:0] dn;
        logic [P-1:0]   sn;
        logic           cn, coin_any, edge_seen;
        logic [3:0]     rise;
        dn = '1;
        for (int p = 0; p < P; p++) begin
`ifdef JOY_FOURWAY_EN
            rise = m_deb[p][3:0] & ~m_prev[p];
            if (rise != 4'b0) m_last[p] = first_held(rise);
            else if (m_last[p] >= 0 && !m_deb[p][m_last[p]]) m_last[p] = first_held(m_deb[p][3:0]);
            if (m_last[p] >= 0) dn[p*4 + nib_pos(m_last[p])] = 1'b0;
`else
            rise = '0;
            for (int b = 0; b < 4; b++) dn[p*4 + nib_pos(b)] = ~m_deb[p][b];
`endif
            m_prev[p] = m_deb[p][3:0] | rise & 4'b0;
            sn[p] = ~m_deb[p][5];
        end
        coin_any = 1'b0;
        for (int p = 0; p < P; p++) coin_any = coin_any | m_deb[p][4];
        edge_seen = coin_any && !mc_prev;
        mc_prev = coin_any;
        if (mc_mode == M_IDLE) begin
            if (edge_seen) begin
                mc_mode = M_PULSE; mc_left = CF; mc_count = (mc_count + 1) % 256;
            end
        end else if (mc_mode == M_PULSE) begin
            if (edge_seen) mc_pend = 1;
            if (ce) begin
                mc_left--;
                if (mc_left == 0) begin mc_mode = M_GAP; mc_left = CG; end
            end
        end else begin
            if (ce && mc_left == 1) begin
                if (mc_pend == 1 || edge_seen) begin
                    mc_mode = M_PULSE; mc_left = CF; mc_pend = 0;
                    mc_count = (mc_count + 1) % 256;
                end else begin
                    mc_mode = M_IDLE; mc_left = 0;
                end
            end else begin
                if (edge_seen) mc_pend = 1;
                if (ce) mc_left--;
            end
        end
        cn = (mc_mode != M_PULSE);
        // Debounce: a bit is accepted after DB consecutive disagreeing frames.
        if (DB == 0) begin
            for (int p = 0; p < P; p++) for (int b = 0; b < 6; b++) m_deb[p][b] = j[p*16+b];
        end else if (ce) begin
            for (int p = 0; p < P; p++) begin
                for (int b = 0; b < 6; b++) begin
                    if (m_raw[p*16+b] != m_deb[p][b]) begin
                        m_cnt[p][b]++;
                        if (m_cnt[p][b] == DB) begin
                            m_deb[p][b] = m_raw[p*16+b];
                            m_cnt[p][b] = 0;
                        end
                    end else begin
                        m_cnt[p][b] = 0;
                    end
                end
            end
        end
        m_raw = j;
        exp_q.push_back({dn, sn, cn, 8'(mc_count)});
    endtask

    // Monitor: one expected output word per clock, compared away from the edge.
    always @(negedge clk) begin
        logic [P*4+P+1+8-1:0] e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {bus.dir_n, bus.start_n, bus.coin_n, bus.coin_count};
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL outputs t=%0t got dir_n=%h start_n=%b coin_n=%b coin_count=%0d, required dir_n=%h start_n=%b coin_n=%b coin_count=%0d",
                         $time, g[P*4+P+8 : P+9], g[P+8:9], g[8], g[7:0],
                         e[P*4+P+8 : P+9], e[P+8:9], e[8], e[7:0]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic step(input logic ce);
        bus.joy = joy_v;
        bus.ce_frame = ce;
        @(posedge clk);
        model_step(joy_v, ce);
        #1;
        bus.ce_frame = 1'b0;
    endtask

    task automatic frame();
        step(1'b1);
        repeat (3) step(1'b0);
    endtask

    task automatic frame_rand();
        step(1'b1);
        repeat ($urandom_range(0, 4)) step(1'b0);
    endtask

    task automatic set_bit(input int p, input int b, input logic v);
        joy_v[p*16+b] = v;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_coin_n"}, 32'(bus.coin_n), 32'd1);
        chk({tag, "_dir_n"}, 32'(bus.dir_n), 32'((1 << (P*4)) - 1));
        chk({tag, "_start_n"}, 32'(bus.start_n), 32'((1 << P) - 1));
        chk({tag, "_coin_count"}, 32'(bus.coin_count), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        joy_v = '0;
        bus.joy = '0;
        bus.ce_frame = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_reset_values("reset");
        reset_n = 1'b1;

        repeat (3) frame();
        // Debounce: a one-frame press must not reach the outputs.
        set_bit(0, 3, 1'b1); frame();
        set_bit(0, 3, 1'b0); repeat (3) frame();
        // Held up, then left added, left released, up released.
        set_bit(0, 3, 1'b1); repeat (3) frame();
        set_bit(0, 1, 1'b1); repeat (3) frame();
        set_bit(0, 1, 1'b0); repeat (3) frame();
        set_bit(0, 3, 1'b0); repeat (3) frame();
        // Up and down together, then start on player 1.
        set_bit(1, 3, 1'b1); set_bit(1, 2, 1'b1); repeat (3) frame();
        joy_v = '0; set_bit(1, 5, 1'b1); repeat (3) frame();
        // Player 2 up+left.
        joy_v = '0; set_bit(2, 3, 1'b1); set_bit(2, 1, 1'b1); repeat (3) frame();
        joy_v = '0; repeat (3) frame();
        // Single coin.
        set_bit(1, 4, 1'b1); repeat (3) frame();
        set_bit(1, 4, 1'b0); repeat (12) frame();
        // Repeated coin edges while a pulse is running.
        for (int k = 0; k < 3; k++) begin
            set_bit(k, 4, 1'b1); repeat (2) frame();
            set_bit(k, 4, 1'b0); repeat (2) frame();
        end
        repeat (14) frame();

        // Reset during a coin pulse with a direction held.
        set_bit(0, 4, 1'b1); set_bit(0, 3, 1'b1);
        for (int k = 0; k < 20 && mc_mode != M_PULSE; k++) frame();
        step(1'b0);
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        check_reset_values("midpulse_reset");
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_reset_values("held_reset");
        reset_n = 1'b1;
        model_reset();
        joy_v = '0;
        repeat (4) frame();

        // Random activity.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0)
                joy_v[$urandom_range(0, P-1)*16 + $urandom_range(0, 5)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0)
                joy_v[$urandom_range(0, P-1)*16 + $urandom_range(6, 15)] ^= 1'b1;
            frame_rand();
        end
        joy_v = '0;
        repeat (20) frame();

        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arcade_joy_mapper.md
# arcade_joy_mapper

Parametrised player-input conditioner between `hps_io` joystick words and the game core's active-low input ports. It succeeds the fixed two-player inline mapping with a block that handles any number of players from 1 to 4. It adds per-bit debounce, 4-way direction resolution, a shaped coin pulse with one queued insert, and a coin counter. It sits in `emu` between `hps_io` and the `IN0`/`IN1`/`IN2` assembly.

## Interface
Parameters:
- `PLAYERS`, default 2: number of players, 1..4.
- `DEBOUNCE_FRAMES`, default 2: number of consecutive stable frame samples required before a bit changes. 0 bypasses debounce.
- `COIN_FRAMES`, default 4: coin pulse width in frames, 1..255.
- `COIN_GAP_FRAMES`, default 4: minimum high time between coin pulses, 1..255.

Ports:
- `clk`, in, 1: system clock (`clk_sys`). This is the only clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `ce_frame`, in, 1: one-cycle strobe per frame, driven at the vblank rising edge.
- `joy`, in, `PLAYERS*16`: packed MiSTer joystick words; player *p* occupies `[16p+15:16p]`. Bit assignment: bit 0 right, bit 1 left, bit 2 down, bit 3 up, bit 4 coin, bit 5 start.
- `dir_n`, out, `PLAYERS*4`: active-low directions per player, nibble order `{left,down,right,up}`.
- `start_n`, out, `PLAYERS`: active-low start, one bit per player.
- `coin_n`, out, 1: active-low shaped coin pulse.
- `coin_count`, out, 8: count of coin pulses issued; wraps 255 → 0.

## Operation
- **Input register.** `joy` is registered every `clk`. It is already in the `clk` domain, so no synchroniser is used.
- **Debounce.** Applies per bit to the 6 used bits of each player.
  - Each bit has a counter of width `$clog2(DEBOUNCE_FRAMES+1)`.
  - On each `ce_frame`: if the raw bit differs from the debounced value, the counter increments. Otherwise the counter clears.
  - When the counter reaches `DEBOUNCE_FRAMES`, the debounced value takes the raw value and the counter clears.
  - `DEBOUNCE_FRAMES=0`: the debounced value equals the registered raw bit on every `clk`.
- **4-way resolver.** One per player; see Configuration.
  - Each resolver holds `last`, a one-hot direction or none.
  - A newly asserted direction (debounced 0→1) becomes `last`.
  - If several directions assert on the same update, priority is up > down > left > right.
  - If `last` releases, `last` becomes the highest-priority direction still held, or none.
  - Output is the one-hot `last`, inverted.
- **Coin FSM.** Input is the OR of all debounced coin bits. A rising edge is detected on the debounced value.
  - `IDLE`: on an edge → `PULSE`, load the timer with `COIN_FRAMES`, increment `coin_count`.
  - `PULSE`: `coin_n`=0. Decrement on `ce_frame`. At 0 → `GAP`, load the timer with `COIN_GAP_FRAMES`.
  - `GAP`: `coin_n`=1. Decrement on `ce_frame`. At 0 → `PULSE` if `pending`, otherwise `IDLE`.
  - An edge arriving in `PULSE` or `GAP` sets `pending`. `pending` saturates at 1, so further edges are dropped.
  - Entering `PULSE` from `GAP` clears `pending` and increments `coin_count`.
- **Start.** `start_n` is the debounced start bit, inverted.
- **Reset values.** `dir_n`, `start_n` and `coin_n` are all ones. `coin_count`=0. FSM is `IDLE`. `pending`=0. All debounced values, counters and `last` are cleared.
  - Reset asserted mid-pulse forces `coin_n` high on the same edge of `reset_n`, asynchronously.

## Timing
- All outputs are registered.
- Raw-to-debounced latency:
  - `DEBOUNCE_FRAMES=0`: 1 clk.
  - Otherwise: the `DEBOUNCE_FRAMES`-th `ce_frame` after the change is registered.
- Debounced-to-output latency is 1 clk, for both the resolver and start.
- `coin_n` falls 1 clk after the debounced coin rises.
- The timer decrements only on `ce_frame`, so pulse width is `COIN_FRAMES` frame strobes. The first strobe counts even if it falls in the same clk as pulse entry + 1.
- A `ce_frame` that coincides with reaching 0 performs the state transition on that same clk.
- With `ce_frame` held low, everything holds except the input register. When `DEBOUNCE_FRAMES=0`, the resolver and start outputs also continue to track.

## Configuration
- `JOY_FOURWAY_EN` defined: the 4-way resolver is instantiated per player, and at most one bit of each `dir_n` nibble is 0.
- Not defined: `dir_n` is the debounced directions passed through inverted. Opposite and diagonal combinations pass unmodified.

## Structure
- Package `arcade_input_pkg`:
  - `joy_bit_e` bit-index constants (RIGHT=0..START=5).
  - `dir4_t` packed `{left,down,right,up}`.
  - `coin_state_e` (`IDLE`, `PULSE`, `GAP`).
- Sub-module `joy_fourway` with ports `clk`, `reset_n`, `dir_in` [3:0], `dir_out_n` [3:0]. It is generated `PLAYERS` times under `JOY_FOURWAY_EN`.

## Test plan
- **Reset.** Assert `reset_n`=0 mid-pulse → `coin_n`=1, `dir_n`=all ones, `coin_count`=0 immediately. Outputs stay so until the first input after release.
- **Debounce.** `DEBOUNCE_FRAMES=2`: hold up for 1 `ce_frame` and release → no output change. Hold for 2 → `dir_n` nibble becomes 4'b1110 on the clk after the 2nd strobe.
- **4-way.** Hold up, then add left → nibble 4'b0111. Release left → 4'b1110. Assert up and down on the same update → 4'b1110.
- **Coin.** `COIN_FRAMES=4`, `GAP=4`: a single coin edge → `coin_n` low for exactly 4 strobes, `coin_count`=1.
- **Coin queueing.** 3 coin edges during one `PULSE` → exactly 2 pulses separated by 4 gap strobes, `coin_count`=2.
- **Pass-through.** `JOY_FOURWAY_EN` undefined, `PLAYERS=3`: player 2 presses up+left → `dir_n[11:8]`=4'b0110. Players 0 and 1 stay at 4'b1111.
